// File: rtl/tank_canvas_pkg.sv
// Shared canvas constants, pixel type, blitter opcodes and FSM encoding for the
// tank game VRAM path.
package tank_canvas_pkg;

   localparam int H_LEN = 200;
   localparam int V_LEN = 150;
   localparam int DW    = 15;
   localparam int SW    = 12;

   typedef logic [11:0] rgb_t;

   localparam logic [1:0] OP_FILL   = 2'd0;
   localparam logic [1:0] OP_CLEAR  = 2'd1;
   localparam logic [1:0] OP_SPRITE = 2'd2;

   localparam rgb_t KEY = 12'h000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } blit_state_t;

endpackage

// File: rtl/vram_blit_walker.sv
// Row-major 2D walker for the blitter: column/row counters plus destination and
// source row-base accumulators, exposing the current pixel's addresses.
module blit_walker
#(
   parameter int H_LEN = 200,
   parameter int DW    = 15,
   parameter int SW    = 12
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          load,
   input  logic          step,
   input  logic [7:0]    w_eff,
   input  logic [7:0]    h_eff,
   input  logic [7:0]    stride,
   input  logic [DW-1:0] start,
   output logic [DW-1:0] dst,
   output logic [SW-1:0] src,
   output logic          last_col,
   output logic          last_row
);

   logic [7:0]    col_r;
   logic [7:0]    row_r;
   logic [7:0]    w_r;
   logic [7:0]    h_r;
   logic [7:0]    stride_r;
   logic [DW-1:0] dst_row_r;
   logic [SW-1:0] src_row_r;

   // Counter and row-base update: load at region start, advance one pixel per step.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         col_r     <= 8'd0;
         row_r     <= 8'd0;
         w_r       <= 8'd0;
         h_r       <= 8'd0;
         stride_r  <= 8'd0;
         dst_row_r <= '0;
         src_row_r <= '0;
      end else if (load) begin
         col_r     <= 8'd0;
         row_r     <= 8'd0;
         w_r       <= w_eff;
         h_r       <= h_eff;
         stride_r  <= stride;
         dst_row_r <= start;
         src_row_r <= '0;
      end else if (step) begin
         if (last_col) begin
            // Source advances by the unclipped sprite width so clipped rows stay aligned.
            col_r     <= 8'd0;
            row_r     <= row_r + 8'd1;
            dst_row_r <= dst_row_r + DW'(H_LEN);
            src_row_r <= src_row_r + SW'(stride_r);
         end else begin
            col_r <= col_r + 8'd1;
         end
      end else begin
         col_r <= col_r;
      end
   end

   assign dst      = dst_row_r + DW'(col_r);
   assign src      = src_row_r + SW'(col_r);
   assign last_col = (col_r == (w_r - 8'd1));
   assign last_row = (row_r == (h_r - 8'd1));

endmodule

// File: rtl/vram_blit.sv
// Rectangle/sprite blitter writing the 200x150 12-bit canvas VRAM, one pixel per cycle.
// SPRITE op and colour-key transparency are built only when VRAM_BLIT_SPRITE_EN is defined.
module vram_blit
   import tank_canvas_pkg::*;
#(
   parameter int          H_LEN = tank_canvas_pkg::H_LEN,
   parameter int          V_LEN = tank_canvas_pkg::V_LEN,
   parameter int          DW    = tank_canvas_pkg::DW,
   parameter int          SW    = tank_canvas_pkg::SW,
   parameter logic [11:0] KEY   = tank_canvas_pkg::KEY
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [7:0]    cmd_x,
   input  logic [7:0]    cmd_y,
   input  logic [7:0]    cmd_w,
   input  logic [7:0]    cmd_h,
   input  logic [11:0]   cmd_color,
   input  logic [SW-1:0] cmd_sbase,
   output logic [SW-1:0] spr_addr,
   input  logic [11:0]   spr_data,
   output logic          we,
   output logic [DW-1:0] waddr,
   output logic [11:0]   wdata,
   output logic          busy,
   output logic          done
);

   blit_state_t   state_r;
   blit_state_t   state_s;

   logic [1:0]    op_r;
   logic [7:0]    x_r;
   logic [7:0]    y_r;
   logic [7:0]    w_r;
   logic [7:0]    h_r;
   rgb_t          color_r;
   logic [SW-1:0] sbase_r;

   logic [8:0]    room_x_s;
   logic [8:0]    room_y_s;
   logic [7:0]    w_eff_s;
   logic [7:0]    h_eff_s;
   logic [DW-1:0] start_s;
   logic          off_canvas_s;
   logic          skip_s;

   logic          load_s;
   logic          step_s;
   logic [DW-1:0] dst_s;
   logic [SW-1:0] src_s;
   logic          last_col_s;
   logic          last_row_s;

   logic          we_s;
   logic [DW-1:0] waddr_s;
   rgb_t          wdata_s;

`ifdef VRAM_BLIT_SPRITE_EN
   logic          pend_r;
   logic          pend_s;
   logic [DW-1:0] pend_addr_r;
   logic [DW-1:0] pend_addr_s;
`endif

   // y * H_LEN as a sum of shifted copies of y, one per set bit of the constant.
   function automatic logic [DW-1:0] times_hlen(input logic [7:0] y);
      logic [DW-1:0] acc;
      acc = '0;
      for (int i = 0; i < 16; i++) begin
         if (H_LEN[i]) acc = acc + (DW'(y) << i);
         else          acc = acc;
      end
      return acc;
   endfunction

   assign cmd_ready = (state_r == ST_IDLE);

   // Command latch: every field captured on the accepting edge.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         op_r    <= 2'd0;
         x_r     <= 8'd0;
         y_r     <= 8'd0;
         w_r     <= 8'd0;
         h_r     <= 8'd0;
         color_r <= 12'h000;
         sbase_r <= '0;
      end else if (cmd_valid && (state_r == ST_IDLE)) begin
         op_r    <= cmd_op;
         x_r     <= cmd_x;
         y_r     <= cmd_y;
         w_r     <= cmd_w;
         h_r     <= cmd_h;
         color_r <= cmd_color;
         sbase_r <= cmd_sbase;
      end else begin
         op_r <= op_r;
      end
   end

   // Clipped region and start address, consumed in SETUP.
   always_comb begin
      room_x_s = 9'(H_LEN) - {1'b0, x_r};
      room_y_s = 9'(V_LEN) - {1'b0, y_r};
      if (op_r == OP_CLEAR) begin
         w_eff_s = 8'(H_LEN);
         h_eff_s = 8'(V_LEN);
         start_s = '0;
      end else begin
         if ({1'b0, w_r} < room_x_s) w_eff_s = w_r;
         else                        w_eff_s = room_x_s[7:0];
         if ({1'b0, h_r} < room_y_s) h_eff_s = h_r;
         else                        h_eff_s = room_y_s[7:0];
         start_s = DW'(x_r) + times_hlen(y_r);
      end
   end

   assign off_canvas_s = ({1'b0, x_r} >= 9'(H_LEN)) || ({1'b0, y_r} >= 9'(V_LEN)) ||
                         (w_r == 8'd0) || (h_r == 8'd0);

   // Commands that produce no writes and go straight to DONE.
   always_comb begin
      case (op_r)
         OP_FILL:   skip_s = off_canvas_s;
         OP_CLEAR:  skip_s = 1'b0;
`ifdef VRAM_BLIT_SPRITE_EN
         OP_SPRITE: skip_s = off_canvas_s;
`else
         OP_SPRITE: skip_s = 1'b1;
`endif
         default:   skip_s = 1'b1;
      endcase
   end

   blit_walker #(
      .H_LEN (H_LEN),
      .DW    (DW),
      .SW    (SW)
   ) u_walker (
      .clk      (clk),
      .rstn     (rstn),
      .load     (load_s),
      .step     (step_s),
      .w_eff    (w_eff_s),
      .h_eff    (h_eff_s),
      .stride   (w_r),
      .start    (start_s),
      .dst      (dst_s),
      .src      (src_s),
      .last_col (last_col_s),
      .last_row (last_row_s)
   );

`ifdef VRAM_BLIT_SPRITE_EN
   // ROM address for the pixel the walker is on; data returns next cycle.
   assign spr_addr = sbase_r + src_s;
`else
   logic unused_s;
   assign unused_s = ^{spr_data, src_s, sbase_r, KEY};
   assign spr_addr = '0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rstn) state_r <= ST_IDLE;
      else       state_r <= state_s;
   end

   // Next state and next-cycle VRAM write.
   always_comb begin
      state_s = state_r;
      load_s  = 1'b0;
      step_s  = 1'b0;
      we_s    = 1'b0;
      waddr_s = waddr;
      wdata_s = wdata;
`ifdef VRAM_BLIT_SPRITE_EN
      pend_s      = 1'b0;
      pend_addr_s = pend_addr_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) state_s = ST_SETUP;
            else           state_s = ST_IDLE;
         end
         ST_SETUP: begin
            if (skip_s) begin
               state_s = ST_DONE;
            end else begin
               load_s  = 1'b1;
               state_s = ST_RUN;
            end
         end
         ST_RUN: begin
            step_s = 1'b1;
`ifdef VRAM_BLIT_SPRITE_EN
            if (op_r == OP_SPRITE) begin
               pend_s      = 1'b1;
               pend_addr_s = dst_s;
            end else begin
               we_s    = 1'b1;
               waddr_s = dst_s;
               wdata_s = color_r;
            end
`else
            we_s    = 1'b1;
            waddr_s = dst_s;
            wdata_s = color_r;
`endif
            if (last_col_s && last_row_s) state_s = ST_DRAIN;
            else                          state_s = ST_RUN;
         end
         ST_DRAIN: state_s = ST_DONE;
         ST_DONE:  state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
`ifdef VRAM_BLIT_SPRITE_EN
      // Sprite pixel read last cycle lands now; key-coloured pixels are skipped.
      if (pend_r) begin
         we_s    = (spr_data != KEY);
         waddr_s = pend_addr_r;
         wdata_s = spr_data;
      end else begin
         we_s = we_s;
      end
`endif
   end

   // Output and pipeline registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         we    <= 1'b0;
         waddr <= '0;
         wdata <= 12'h000;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef VRAM_BLIT_SPRITE_EN
         pend_r      <= 1'b0;
         pend_addr_r <= '0;
`endif
      end else begin
         we    <= we_s;
         waddr <= waddr_s;
         wdata <= wdata_s;
         busy  <= (state_s != ST_IDLE);
         done  <= (state_r == ST_DONE);
`ifdef VRAM_BLIT_SPRITE_EN
         pend_r      <= pend_s;
         pend_addr_r <= pend_addr_s;
`endif
      end
   end

endmodule

// File: doc/vram_blit.md
# vram_blit

Rectangle and sprite blitter that writes the 200×150, 12-bit RGB canvas VRAM. It sits upstream of the display readout stage: game logic issues draw commands, and this block turns each command into one VRAM write per cycle on the VRAM write port. The display path reads the other port of the same dual-port VRAM. Clipping to the canvas edge and sprite transparency are handled here, so producers may issue commands with off-canvas coordinates.

## Interface
- H_LEN, 200, canvas width in pixels
- V_LEN, 150, canvas height in pixels
- DW, 15, VRAM address width
- SW, 12, sprite ROM address width
- KEY, 12'h000, transparent colour for sprites
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid && ready
- cmd_op  in  2  0 FILL, 1 CLEAR, 2 SPRITE, 3 reserved (treated as no-op)
- cmd_x, cmd_y  in  8 each  top-left corner
- cmd_w, cmd_h  in  8 each  size in pixels
- cmd_color  in  12  fill/clear colour
- cmd_sbase  in  SW  sprite base address in ROM
- spr_addr  out  SW  sprite ROM read address
- spr_data  in  12  sprite ROM data, synchronous, 1-cycle latency
- we  out  1  VRAM write enable
- waddr  out  DW  VRAM address, y*H_LEN + x
- wdata  out  12  VRAM data
- busy  out  1  high from acceptance until done
- done  out  1  one-cycle pulse at command completion

## Operation
- FSM states: IDLE → SETUP → RUN → DRAIN → DONE → IDLE.
- cmd_ready = (state == IDLE). All command fields are latched on acceptance.
- SETUP computes the clipped region:
  - w_eff = min(w, H_LEN−x), h_eff = min(h, V_LEN−y).
  - CLEAR forces x=y=0, w_eff=H_LEN, h_eff=V_LEN.
  - If x≥H_LEN, y≥V_LEN, w=0, h=0, or op==3: go directly to DONE with no writes.
  - The start address is x + y*H_LEN, formed by a shift-add; no generic multiplier.
- RUN walks the region row-major, one pixel per cycle.
  - The column counter wraps at w_eff.
  - On wrap, the destination row base adds H_LEN and the source row base adds w (the unclipped sprite stride).
- FILL and CLEAR: we=1 and wdata=color on every RUN cycle.
- SPRITE: spr_addr = sbase + row*w + col is issued in RUN. The write follows one cycle later from spr_data. When spr_data == KEY, we=0 for that pixel, but the address still advances.
- DRAIN lasts one cycle and covers the final sprite write. FILL and CLEAR pass through DRAIN with we=0.
- DONE pulses done=1 for one cycle. busy drops in the same cycle.
- cmd_valid while busy is held off; nothing is dropped, and the producer keeps valid asserted.
- Reset values: we=0, waddr=0, wdata=0, spr_addr=0, busy=0, done=0, state=IDLE.
- Reset mid-command: writes stop on the next edge and the command is lost.
- Address arithmetic is DW bits wide. Because of clipping, the maximum address is H_LEN*V_LEN−1 = 29999.

## Timing
- FILL/CLEAR, accepted at edge T:
  - SETUP at T+1.
  - Writes on T+2 … T+1+w_eff*h_eff.
  - done at T+2+w_eff*h_eff (DRAIN) +1.
  - Total latency is w_eff*h_eff+3 cycles.
- SPRITE: reads on T+2 …; writes are one cycle behind. done arrives at the same cycle count as FILL with the same size.
- Fully clipped command: done at T+2.
- Back-to-back commands: the next acceptance is possible one cycle after done (IDLE).
- CLEAR = 30000 writes + 3 cycles. This fits in vertical blanking only if the team issues it there; the block enforces no frame sync.

## Configuration
- VRAM_BLIT_SPRITE_EN defined: SPRITE op, spr_addr/spr_data ports, and KEY transparency are present.
- VRAM_BLIT_SPRITE_EN undefined:
  - The ports are kept, with spr_addr tied to 0 and spr_data ignored.
  - cmd_op==2 behaves as a no-op: done at T+2, no writes.
  - FILL/CLEAR timing is unchanged.

## Structure
- Shared package tank_canvas_pkg: H_LEN, V_LEN, DW, rgb_t (12-bit), opcode localparams OP_FILL/OP_CLEAR/OP_SPRITE, and the default KEY.
- One sub-module, blit_walker: the 2D column/row counter with the two row-base accumulators. It outputs dst address, src offset, and last-pixel flags.
- The FSM, clipping and output registers stay in vram_blit.

## Test plan
- FILL x=10,y=5,w=3,h=2,color=12'hF00 → writes at 1010,1011,1012,1210,1211,1212, all data F00. done at T+9.
- FILL x=198,y=148,w=5,h=5 → clipped to 2×2. Writes at 29798,29799,29998,29999 only.
- CLEAR color=12'h00F → exactly 30000 writes, addresses 0…29999 in order, done at T+30003. cmd_ready is low throughout.
- SPRITE x=0,y=0,w=2,h=2, ROM {0x123,KEY,0x456,0x789} at sbase=16 → spr_addr 16,17,18,19. Writes at 0 (0x123), 200 (0x456), 201 (0x789); address 1 is not written.
- x=200 or w=0 → no we, done at T+2. cmd_valid held during a busy FILL is accepted the cycle after done.
- rstn low mid-CLEAR → we=0 and busy=0 on the next edge, and the next command starts cleanly from IDLE.
